// File: rtl/imem_pair_if.sv
// Fetch and program-load signal bundle between the core/host side and imem_pair_server.
// The master side drives fetch addresses and load traffic; the slave side returns pairs and load status.
interface imem_pair_if #(
  parameter int ADDR_W = 12
);
  logic [31:0]       fetch_addr;
  logic [63:0]       fetch_data;
  logic              fetch_valid;
  logic              fetch_err;
  logic              ld_start;
  logic              ld_we;
  logic [31:0]       ld_wdata;
  logic              ld_done;
  logic              ld_busy;
  logic [ADDR_W-1:0] ld_count;
  logic              ld_ovf;

  modport master (
    output fetch_addr, ld_start, ld_we, ld_wdata, ld_done,
    input  fetch_data, fetch_valid, fetch_err, ld_busy, ld_count, ld_ovf
  );

  modport slave (
    input  fetch_addr, ld_start, ld_we, ld_wdata, ld_done,
    output fetch_data, fetch_valid, fetch_err, ld_busy, ld_count, ld_ovf
  );
endinterface

// File: rtl/imem_pair_server.sv
// Dual-instruction fetch responder: even/odd word banks return {inst@addr+4, inst@addr}
// one cycle after the address, plus a streaming program-load FSM that blocks fetch while loading.
module imem_pair_server #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  imem_pair_if.slave   bus
);
  localparam int ROW_W = ADDR_W - 1;
  localparam int ROWS  = 2 ** ROW_W;

  typedef enum logic {IDLE, LOAD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;

  logic [31:0] mem_even [ROWS];
  logic [31:0] mem_odd  [ROWS];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_idx  = count_q;
    if (bus.ld_start) begin
      // A start always (re)opens the load at word 0, even from LOAD.
      state_d = LOAD;
      ovf_d   = 1'b0;
      wr_idx  = '0;
      wr_en   = bus.ld_we;
      count_d = bus.ld_we ? ADDR_W'(1) : '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.ld_we) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == '1) state_d = IDLE;
          end
          if (bus.ld_done) state_d = IDLE;
        end
        default: begin
          if (bus.ld_we) ovf_d = 1'b1;
        end
      endcase
    end
  end

  // Fetch side: word w and w+1 (mod depth) always live in opposite banks.
  logic [ADDR_W-1:0] w, w1;
  logic [ROW_W-1:0]  even_row, odd_row;
  logic              aligned, rd_en;
  logic              unused_addr_hi;

  assign w              = bus.fetch_addr[ADDR_W+1:2];
  assign w1             = w + 1'b1;
  assign even_row       = w[0] ? w1[ADDR_W-1:1] : w[ADDR_W-1:1];
  assign odd_row        = w[ADDR_W-1:1];
  assign aligned        = (bus.fetch_addr[1:0] == 2'b00);
  assign rd_en          = (state_q == IDLE) && aligned;
  assign unused_addr_hi = ^bus.fetch_addr[31:ADDR_W+2];

  // NOTE: memory arrays carry no reset so they map onto plain RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      if (wr_idx[0]) mem_odd[wr_idx[ADDR_W-1:1]]  <= bus.ld_wdata;
      else           mem_even[wr_idx[ADDR_W-1:1]] <= bus.ld_wdata;
    end
  end

  logic [31:0] even_q, odd_q;
  logic        swap_q, valid_q, err_q;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      even_q <= mem_even[even_row];
      odd_q  <= mem_odd[odd_row];
      swap_q <= w[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= rd_en;
      err_q   <= (state_q == IDLE) && !aligned;
    end
  end

  // Odd start word means the low instruction came from the odd bank.
  always_comb begin
    bus.fetch_data = {NOP_INST, NOP_INST};
    if (valid_q) bus.fetch_data = swap_q ? {even_q, odd_q} : {odd_q, even_q};
  end

  assign bus.fetch_valid = valid_q;
  assign bus.fetch_err   = err_q;
  assign bus.ld_busy     = (state_q == LOAD);
  assign bus.ld_count    = count_q;
  assign bus.ld_ovf      = ovf_q;
endmodule

// File: tb/tb_imem_pair_server.sv
// Self-checking bench for imem_pair_server (ADDR_W=3): directed table, corner sequences,
// and randomized traffic scored against a word-array reference model.
module tb_imem_pair_server;
  localparam int          AW    = 3;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [63:0] NOP2  = {NOP, NOP};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_pair_if #(.ADDR_W(AW)) bus ();

  imem_pair_server #(.ADDR_W(AW), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain word array plus load bookkeeping.
  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_count;
  bit          m_ovf;
  logic [63:0] e_data;
  bit          e_valid, e_err;

  typedef struct {
    bit          st;
    bit          we;
    logic [31:0] wd;
    bit          dn;
    logic [31:0] addr;
    logic [63:0] data;
    bit          valid;
    bit          err;
    bit          busy;
    logic [2:0]  count;
    bit          ovf;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit we, input logic [31:0] d,
                      input bit dn, input logic [31:0] a);
    int w;
    rst             = r;
    bus.ld_start    = st;
    bus.ld_we       = we;
    bus.ld_wdata    = d;
    bus.ld_done     = dn;
    bus.fetch_addr  = a;
    if (r) begin
      e_data = NOP2; e_valid = 0; e_err = 0;
      m_busy = 0; m_count = 0; m_ovf = 0;
    end else begin
      if (m_busy) begin
        e_data = NOP2; e_valid = 0; e_err = 0;
      end else if (a[1:0] != 2'b00) begin
        e_data = NOP2; e_valid = 0; e_err = 1;
      end else begin
        w = int'((a >> 2) % DEPTH);
        e_data = {m_mem[(w + 1) % DEPTH], m_mem[w]};
        e_valid = 1; e_err = 0;
      end
      if (st) begin
        m_busy = 1; m_ovf = 0; m_count = 0;
        if (we) begin m_mem[0] = d; m_count = 1; end
      end else if (m_busy) begin
        if (we) begin
          m_mem[m_count] = d;
          m_count = (m_count + 1) % DEPTH;
          if (m_count == 0) m_busy = 0;
        end
        if (dn) m_busy = 0;
      end else if (we) begin
        m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    check("model_data",  bus.fetch_data,  e_data);
    check("model_valid", 64'(bus.fetch_valid), 64'(e_valid));
    check("model_err",   64'(bus.fetch_err),   64'(e_err));
    check("model_busy",  64'(bus.ld_busy),     64'(m_busy));
    check("model_count", 64'(bus.ld_count),    64'(m_count));
    check("model_ovf",   64'(bus.ld_ovf),      64'(m_ovf));
    rst = 1'b0;
  endtask

  task automatic idle(input logic [31:0] a);
    step(0, 0, 0, 32'h0, 0, a);
  endtask

  initial begin
    bus.fetch_addr = 32'h2;
    bus.ld_start   = 0;
    bus.ld_we      = 0;
    bus.ld_wdata   = 0;
    bus.ld_done    = 0;

    //            st we wd        dn addr    data                       v  e  busy cnt  ovf
    tbl[0]  = '{1, 0, 32'h0,  0, 32'h2,  NOP2,                      0, 1, 1, 3'd0, 0};
    tbl[1]  = '{0, 1, 32'h11, 0, 32'h2,  NOP2,                      0, 0, 1, 3'd1, 0};
    tbl[2]  = '{0, 1, 32'h22, 0, 32'h2,  NOP2,                      0, 0, 1, 3'd2, 0};
    tbl[3]  = '{0, 1, 32'h33, 0, 32'h2,  NOP2,                      0, 0, 1, 3'd3, 0};
    tbl[4]  = '{0, 1, 32'h44, 0, 32'h2,  NOP2,                      0, 0, 1, 3'd4, 0};
    tbl[5]  = '{0, 0, 32'h0,  1, 32'h0,  NOP2,                      0, 0, 0, 3'd4, 0};
    tbl[6]  = '{0, 0, 32'h0,  0, 32'h0,  {32'h22, 32'h11},          1, 0, 0, 3'd4, 0};
    tbl[7]  = '{0, 0, 32'h0,  0, 32'h4,  {32'h33, 32'h22},          1, 0, 0, 3'd4, 0};
    tbl[8]  = '{0, 0, 32'h0,  0, 32'h8,  {32'h44, 32'h33},          1, 0, 0, 3'd4, 0};
    tbl[9]  = '{0, 0, 32'h0,  0, 32'h2,  NOP2,                      0, 1, 0, 3'd4, 0};
    tbl[10] = '{0, 0, 32'h0,  0, 32'h0,  {32'h22, 32'h11},          1, 0, 0, 3'd4, 0};
    tbl[11] = '{0, 0, 32'h0,  0, 32'h24, {32'h33, 32'h22},          1, 0, 0, 3'd4, 0};

    // Reset state
    step(1, 0, 0, 32'h0, 0, 32'h2);
    step(1, 0, 0, 32'h0, 0, 32'h2);
    check("rst_data",  bus.fetch_data, NOP2);
    check("rst_valid", 64'(bus.fetch_valid), 64'd0);
    check("rst_busy",  64'(bus.ld_busy), 64'd0);
    check("rst_count", 64'(bus.ld_count), 64'd0);
    check("rst_ovf",   64'(bus.ld_ovf), 64'd0);

    // Basic load, pair fetches, misaligned fetch, address aliasing
    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].st, tbl[i].we, tbl[i].wd, tbl[i].dn, tbl[i].addr);
      check($sformatf("tbl%0d_data", i),  bus.fetch_data, tbl[i].data);
      check($sformatf("tbl%0d_valid", i), 64'(bus.fetch_valid), 64'(tbl[i].valid));
      check($sformatf("tbl%0d_err", i),   64'(bus.fetch_err), 64'(tbl[i].err));
      check($sformatf("tbl%0d_busy", i),  64'(bus.ld_busy), 64'(tbl[i].busy));
      check($sformatf("tbl%0d_count", i), 64'(bus.ld_count), 64'(tbl[i].count));
      check($sformatf("tbl%0d_ovf", i),   64'(bus.ld_ovf), 64'(tbl[i].ovf));
    end

    // Full-memory load ends itself on the last word, then write in IDLE flags overflow
    step(0, 1, 1, 32'hA0, 0, 32'h2);
    for (int i = 1; i < 7; i++) step(0, 0, 1, 32'hA0 + i, 0, 32'h2);
    check("full_busy_before_last", 64'(bus.ld_busy), 64'd1);
    check("full_count_before_last", 64'(bus.ld_count), 64'd7);
    step(0, 0, 1, 32'hA7, 0, 32'h2);
    check("full_busy_after_last", 64'(bus.ld_busy), 64'd0);
    check("full_count_wrap", 64'(bus.ld_count), 64'd0);
    check("full_ovf_clear", 64'(bus.ld_ovf), 64'd0);
    idle(32'h1C);
    check("wrap_fetch", bus.fetch_data, {32'hA0, 32'hA7});
    step(0, 0, 1, 32'hDEAD, 0, 32'h2);
    check("idle_we_ovf", 64'(bus.ld_ovf), 64'd1);
    idle(32'h0);
    check("idle_we_no_write", bus.fetch_data, {32'hA1, 32'hA0});
    check("ovf_sticky", 64'(bus.ld_ovf), 64'd1);

    // Fetch blocked during LOAD, resumes after ld_done
    step(0, 1, 0, 32'h0, 0, 32'h4);
    check("start_clears_ovf", 64'(bus.ld_ovf), 64'd0);
    idle(32'h4);
    check("load_blocks_valid", 64'(bus.fetch_valid), 64'd0);
    check("load_blocks_data", bus.fetch_data, NOP2);
    step(0, 0, 1, 32'hB0, 0, 32'h4);
    step(0, 0, 0, 32'h0, 1, 32'h4);
    check("done_busy", 64'(bus.ld_busy), 64'd0);
    idle(32'h4);
    check("after_done_fetch", bus.fetch_data, {32'hA2, 32'hA1});
    check("after_done_valid", 64'(bus.fetch_valid), 64'd1);
    idle(32'h0);
    check("after_done_word0", bus.fetch_data, {32'hA1, 32'hB0});

    // Start+write same cycle, then rst mid-load keeps written words
    step(0, 1, 1, 32'h55, 0, 32'h2);
    check("start_we_count", 64'(bus.ld_count), 64'd1);
    step(0, 0, 1, 32'h66, 0, 32'h2);
    step(0, 0, 1, 32'h77, 0, 32'h2);
    step(1, 0, 0, 32'h0, 0, 32'h2);
    check("midrst_busy", 64'(bus.ld_busy), 64'd0);
    check("midrst_count", 64'(bus.ld_count), 64'd0);
    idle(32'h0);
    check("midrst_kept", bus.fetch_data, {32'h66, 32'h55});
    idle(32'h8);
    check("midrst_kept2", bus.fetch_data, {32'hA3, 32'h77});

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit          r, st, we, dn;
      logic [31:0] a;
      r  = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 14) == 0);
      we = ($urandom_range(0, 2) != 0);
      dn = !st && ($urandom_range(0, 7) == 0);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      step(r, st, we, $urandom, dn, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
